// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU/DMA) arbiter in front of a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module dmem_arbiter #(
  parameter int DEPTH = 102,
  parameter int LANES = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic               cpu_lock,
  input  logic [31:0]        cpu_addr,
  input  logic [LANES*8-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic               cpu_err,
  output logic [LANES*8-1:0] cpu_rdata,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic               dma_lock,
  input  logic [31:0]        dma_addr,
  input  logic [LANES*8-1:0] dma_wdata,
  output logic               dma_gnt,
  output logic               dma_rvalid,
  output logic               dma_err,
  output logic [LANES*8-1:0] dma_rdata,
  output logic               mem_we,
  output logic [31:0]        mem_a,
  output logic [LANES*8-1:0] mem_wd,
  input  logic [LANES*8-1:0] mem_rd
);
  typedef enum logic [1:0] {IDLE, G_CPU, G_DMA} state_t;
  state_t              r_state, w_next;
  logic                r_last;
  logic                w_hold_c, w_hold_d, w_rr, w_pick_dma, w_we, w_valid;
  logic [31:0]         w_addr;
  logic [LANES*8-1:0]  w_wd, w_rsp;
`ifdef DMEM_ARB_RR_EN
  logic                w_last;
  // a grant in the current cycle counts as the most recent one for the next pick
  assign w_last = cpu_gnt ? 1'b0 : dma_gnt ? 1'b1 : r_last;
  assign w_rr   = ~w_last;
`else
  assign w_rr   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_hold_c   = (r_state == G_CPU) & cpu_req & cpu_lock;
    w_hold_d   = (r_state == G_DMA) & dma_req & dma_lock;
    w_pick_dma = dma_req & (~cpu_req | w_rr);
    w_next     = w_hold_c ? G_CPU :
                 w_hold_d ? G_DMA :
                 !(cpu_req | dma_req) ? IDLE :
                 w_pick_dma ? G_DMA : G_CPU;
  end
  always_comb begin
    cpu_gnt = (r_state == G_CPU) & cpu_req;
    dma_gnt = (r_state == G_DMA) & dma_req;
    w_addr  = dma_gnt ? dma_addr  : cpu_gnt ? cpu_addr  : '0;
    w_wd    = dma_gnt ? dma_wdata : cpu_gnt ? cpu_wdata : '0;
    w_we    = dma_gnt ? dma_we    : cpu_gnt & cpu_we;
    w_valid = (w_addr[31:14] == 18'd0) && ({20'd0, w_addr[13:2]} < DEPTH);
    mem_we  = w_we & w_valid;
    mem_a   = w_addr;
    mem_wd  = w_wd;
    w_rsp   = (w_we | ~w_valid) ? '0 : mem_rd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last     <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt;
      cpu_err    <= cpu_gnt & ~w_valid;
      dma_rvalid <= dma_gnt;
      dma_err    <= dma_gnt & ~w_valid;
      if (cpu_gnt) cpu_rdata <= w_rsp;
      if (dma_gnt) dma_rdata <= w_rsp;
      if (cpu_gnt | dma_gnt) r_last <= dma_gnt;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a behavioural data memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_addr;
  logic [47:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_addr;
  logic [47:0] dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [47:0] mem_wd, mem_rd;
  logic [47:0] mem [0:101];
  int          total = 0, bad = 0;
  int          w;
  logic        mwe;
  logic        exp_c;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always @(posedge clk) if (mem_we && mem_a[13:2] < 12'd102) mem[mem_a[13:2]] <= mem_wd;
  assign mem_rd = (mem_a[13:2] < 12'd102) ? mem[mem_a[13:2]] : '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input bit d, input bit we, input logic [31:0] a, input logic [47:0] wd,
                     output int wt, output logic mw);
    if (d) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    #1;
    wt = 0;
    while (!(d ? dma_gnt : cpu_gnt) && wt < 10) begin tick; wt++; end
    mw = mem_we;
    chk("gnt_timeout", 64'(wt < 10), 1);
    tick;
    if (d) begin dma_req = 0; dma_we = 0; end
    else   begin cpu_req = 0; cpu_we = 0; end
    #1;
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_cgnt", cpu_gnt, 0);
    chk("rst_dgnt", dma_gnt, 0);
    chk("rst_crv", cpu_rvalid, 0);
    chk("rst_drv", dma_rvalid, 0);
    chk("rst_cerr", cpu_err, 0);
    chk("rst_crd", cpu_rdata, 0);
    chk("rst_drd", dma_rdata, 0);
    chk("rst_we", mem_we, 0);
    cpu_req = 1; #1;
    chk("rst_hold_idle", cpu_gnt, 0);
    cpu_req = 0;
    tick; tick;
    rst_n = 1;
    // CPU write then read-back of byte address 0x10
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 48'h0A0B0C0D0E0F; #1;
    chk("w_gnt_idle", cpu_gnt, 0);
    tick;
    chk("w_gnt", cpu_gnt, 1);
    chk("w_we", mem_we, 1);
    chk("w_a", mem_a, 32'h10);
    chk("w_wd", mem_wd, 48'h0A0B0C0D0E0F);
    chk("w_rv_early", cpu_rvalid, 0);
    tick;
    cpu_req = 0; cpu_we = 0; #1;
    chk("w_gnt_once", cpu_gnt, 0);
    chk("w_rv", cpu_rvalid, 1);
    chk("w_err", cpu_err, 0);
    chk("w_rd0", cpu_rdata, 0);
    tick;
    chk("w_rv_pulse", cpu_rvalid, 0);
    acc(0, 0, 32'h10, 0, w, mwe);
    chk("r_lat", w, 1);
    chk("r_we", mwe, 0);
    chk("r_rv", cpu_rvalid, 1);
    chk("r_data", cpu_rdata, 48'h0A0B0C0D0E0F);
    tick;
    // address range boundaries
    acc(0, 1, 32'h198, 48'hFFFF, w, mwe);
    chk("oob_we", mwe, 0);
    chk("oob_rv", cpu_rvalid, 1);
    chk("oob_err", cpu_err, 1);
    chk("oob_rd", cpu_rdata, 0);
    tick;
    chk("oob_err_pulse", cpu_err, 0);
    acc(0, 1, 32'h4000, 48'hFFFF, w, mwe);
    chk("hi_we", mwe, 0);
    chk("hi_err", cpu_err, 1);
    tick;
    acc(0, 0, 32'h198, 0, w, mwe);
    chk("oobr_err", cpu_err, 1);
    chk("oobr_rd", cpu_rdata, 0);
    tick;
    acc(0, 1, 32'h197, 48'h123456789ABC, w, mwe);
    chk("top_we", mwe, 1);
    chk("top_err", cpu_err, 0);
    tick;
    acc(0, 0, 32'h194, 0, w, mwe);
    chk("top_rd", cpu_rdata, 48'h123456789ABC);
    tick;
    // DMA write word 5, CPU read of word 5 granted the very next cycle
    dma_req = 1; dma_we = 1; dma_addr = 32'h14; dma_wdata = 48'hD5D500005555; #1;
    tick;
    chk("dw_gnt", dma_gnt, 1);
    chk("dw_we", mem_we, 1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14; #1;
    chk("dw_cgnt", cpu_gnt, 0);
    tick;
    dma_req = 0; dma_we = 0; #1;
    chk("dw_rv", dma_rvalid, 1);
    chk("dw_err", dma_err, 0);
    chk("cr_gnt", cpu_gnt, 1);
    chk("cr_a", mem_a, 32'h14);
    tick;
    cpu_req = 0; #1;
    chk("cr_rv", cpu_rvalid, 1);
    chk("cr_rd", cpu_rdata, 48'hD5D500005555);
    tick;
    // DMA lock holds the grant against a waiting CPU
    dma_req = 1; dma_lock = 1; dma_addr = 32'h10; #1;
    tick;
    chk("lk_g1", dma_gnt, 1);
    cpu_req = 1; cpu_addr = 32'h14; #1;
    chk("lk_c1", cpu_gnt, 0);
    for (int i = 2; i <= 4; i++) begin
      tick;
      chk("lk_g", dma_gnt, 1);
      chk("lk_c", cpu_gnt, 0);
    end
    dma_lock = 0; #1;
    chk("lk_g4", dma_gnt, 1);
    tick;
    dma_req = 0; #1;
    chk("lk_cgnt", cpu_gnt, 1);
    chk("lk_drv", dma_rvalid, 1);
    chk("lk_drd", dma_rdata, 48'h0A0B0C0D0E0F);
    tick;
    cpu_req = 0; #1;
    chk("lk_crd", cpu_rdata, 48'hD5D500005555);
    tick;
    // simultaneous requests after a fresh reset
    rst_n = 0; #1;
    tick;
    rst_n = 1;
    cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h14; #1;
    chk("both_idle_c", cpu_gnt, 0);
    chk("both_idle_d", dma_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
`ifdef DMEM_ARB_RR_EN
      exp_c = (i % 2 == 0);
`else
      exp_c = 1'b1;
`endif
      chk("arb_c", cpu_gnt, exp_c);
      chk("arb_d", dma_gnt, !exp_c);
    end
    cpu_req = 0; dma_req = 0;
    tick; tick;
    // reset in the middle of a DMA grant cycle
    dma_req = 1; dma_we = 1; dma_addr = 32'h18; dma_wdata = 48'h666666666666; #1;
    tick;
    chk("ra_gnt", dma_gnt, 1);
    chk("ra_we", mem_we, 1);
    rst_n = 0; #1;
    chk("ra_gnt0", dma_gnt, 0);
    chk("ra_we0", mem_we, 0);
    chk("ra_drd", dma_rdata, 0);
    dma_req = 0; dma_we = 0;
    tick;
    rst_n = 1; #1;
    chk("ra_rv0", dma_rvalid, 0);
    tick;
    chk("ra_rv1", dma_rvalid, 0);
    acc(0, 0, 32'h10, 0, w, mwe);
    chk("ra_idle_lat", w, 1);
    chk("ra_rd", cpu_rdata, 48'h0A0B0C0D0E0F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
